pwm_capture: RTL

Multi-channel PWM capture block: samples `n_ch` asynchronous PWM lines on a programmable time-base strobe and measures, per channel, the high time and the period in strobe units. It is the receive-side counterpart of the team's RGB LED PWM driver and is used on loopback/verification boards to read back LED drive waveforms. Results are presented as per-channel registers with a one-cycle valid pulse, ready for a Wishbone register wrapper.

---
 rtl/pwm_capture_pkg.sv | 15 +
 rtl/pwm_capture_if.sv | 37 +++
 rtl/pwm_capture_ch.sv | 115 +++++++++++
 rtl/pwm_capture.sv | 55 +++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared helpers for the PWM capture block.
//   calc_w    : result/counter width for a given PWM resolution (depth+1)
//   calc_tmax : saturation value of a W-bit period counter (2^W-1), which is
//               both the timeout threshold and the period reported on timeout
package pwm_capture_pkg;

  function automatic int calc_w(input int depth);
    return depth + 1;
  endfunction

  function automatic int calc_tmax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: configuration, PWM lines and per-channel results of the
// capture block.
//   enable_i  : capture enable (low clears all capture state)
//   clk_div_i : strobe divider, one sample every clk_div_i+1 clocks
//   pwm_i     : asynchronous PWM inputs, one bit per channel
//   duty_o    : per channel, W bits: strobes sampled high in last period
//   period_o  : per channel, W bits: strobes between the last two rising edges
//   valid_o   : per channel one-cycle pulse when that channel's results update
//   timeout_o : per channel, 1 = last result produced by timeout
// master drives configuration and lines, slave is the capture block.
interface pwm_capture_if #(
  parameter int n_ch  = 6,
  parameter int depth = 8
);
  import pwm_capture_pkg::*;

  localparam int W = calc_w(depth);

  logic                enable_i;
  logic [15:0]         clk_div_i;
  logic [n_ch-1:0]     pwm_i;
  logic [n_ch*W-1:0]   duty_o;
  logic [n_ch*W-1:0]   period_o;
  logic [n_ch-1:0]     valid_o;
  logic [n_ch-1:0]     timeout_o;

  modport master (
    output enable_i, clk_div_i, pwm_i,
    input  duty_o, period_o, valid_o, timeout_o
  );

  modport slave (
    input  enable_i, clk_div_i, pwm_i,
    output duty_o, period_o, valid_o, timeout_o
  );

endinterface

// File: rtl/pwm_capture_ch.sv
// pwm_capture_ch: one capture channel.
//   clk_i, async_rst_i : clock, asynchronous active-high reset
//   enable_i           : low = synchronous clear of all capture state
//   strobe_i           : time-base sample strobe from the top
//   pwm_i              : asynchronous PWM line
//   duty_o, period_o   : last measurement in strobe units (W bits)
//   valid_o            : one-cycle pulse on update
//   timeout_o          : 1 = last result came from a timeout
module pwm_capture_ch
  import pwm_capture_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         async_rst_i,
  input  logic         enable_i,
  input  logic         strobe_i,
  input  logic         pwm_i,
  output logic [W-1:0] duty_o,
  output logic [W-1:0] period_o,
  output logic         valid_o,
  output logic         timeout_o
);

  localparam logic [W-1:0] C_TMAX    = W'(calc_tmax(W));
  localparam logic [W-1:0] C_ONE     = W'(1);
  localparam logic [W-1:0] C_TMAX_M1 = C_TMAX - C_ONE;

  logic [1:0]   r_sync;
  logic         r_p;
  logic         r_armed;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_per;
  logic [W-1:0] r_duty;
  logic [W-1:0] r_period;
  logic         r_valid;
  logic         r_timeout;

  logic         w_s;
  logic         w_rise;
  logic [W-1:0] w_hi_next;

  assign w_s       = r_sync[1];
  assign w_rise    = w_s & ~r_p;
  assign w_hi_next = r_hi + {{(W-1){1'b0}}, w_s};

  // Synchronizer stage: free-running, independent of enable_i.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pwm_i};
    end
  end

  // Measurement stage: edge detect, counters and result registers.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_p       <= 1'b0;
      r_armed   <= 1'b0;
      r_hi      <= '0;
      r_per     <= '0;
      r_duty    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else if (!enable_i) begin
      r_p       <= 1'b0;
      r_armed   <= 1'b0;
      r_hi      <= '0;
      r_per     <= '0;
      r_duty    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (strobe_i) begin
        r_p <= w_s;
        if (w_rise) begin
          if (r_armed) begin
            r_duty    <= r_hi;
            r_period  <= r_per;
            r_timeout <= 1'b0;
            r_valid   <= 1'b1;
          end
          // The edge strobe itself opens the next window, so both counts
          // restart at 1 rather than 0.
          r_armed <= 1'b1;
          r_hi    <= C_ONE;
          r_per   <= C_ONE;
        end else if (r_armed) begin
          // Timeout fires on the strobe that brings the window to 2^W-1,
          // so the reported duty (including this sample) never exceeds it.
          if (r_per == C_TMAX_M1) begin
            r_duty    <= w_hi_next;
            r_period  <= C_TMAX;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            r_armed   <= 1'b0;
          end else begin
            r_per <= r_per + C_ONE;
            r_hi  <= w_hi_next;
          end
        end
      end
    end
  end

  assign duty_o    = r_duty;
  assign period_o  = r_period;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM high-time / period capture.
//   clk_i       : system clock
//   async_rst_i : asynchronous active-high reset
//   bus         : pwm_capture_if.slave (enable, divider, PWM lines, results)
// The top holds the shared strobe generator; each channel is an independent
// pwm_capture_ch instance.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int n_ch  = 6,
  parameter int depth = 8
) (
  input  logic          clk_i,
  input  logic          async_rst_i,
  pwm_capture_if.slave  bus
);

  localparam int W = calc_w(depth);

  logic [15:0] r_div_cnt;
  logic        w_strobe;

  // Counter sits at 0 while disabled, so the first enabled cycle strobes.
  assign w_strobe = bus.enable_i & (r_div_cnt == 16'd0);

  // Strobe stage: divider down-counter, reloads clk_div_i on each strobe.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_div_cnt <= 16'd0;
    end else if (!bus.enable_i) begin
      r_div_cnt <= 16'd0;
    end else if (r_div_cnt == 16'd0) begin
      r_div_cnt <= bus.clk_div_i;
    end else begin
      r_div_cnt <= r_div_cnt - 16'd1;
    end
  end

  for (genvar g = 0; g < n_ch; g++) begin : g_ch
    pwm_capture_ch #(
      .W (W)
    ) u_ch (
      .clk_i       (clk_i),
      .async_rst_i (async_rst_i),
      .enable_i    (bus.enable_i),
      .strobe_i    (w_strobe),
      .pwm_i       (bus.pwm_i[g]),
      .duty_o      (bus.duty_o[g*W +: W]),
      .period_o    (bus.period_o[g*W +: W]),
      .valid_o     (bus.valid_o[g]),
      .timeout_o   (bus.timeout_o[g])
    );
  end

endmodule
